serial_word_deserializer: RTL and testbench

Collects a serial bit stream into WIDTH-bit parallel words and presents each completed word with a valid/ready handshake. It sits directly upstream of the team's enabled, asynchronously-reset D flip-flop register bank. `word` drives the bank's D inputs, and `word_valid && word_ready` drives its enables. Framing is explicit: `start` opens a frame, and WIDTH strobed bits complete it.

---
 rtl/serial_word_deserializer_if.sv | 24 ++
 rtl/serial_word_deserializer.sv | 74 +++++++
 tb/tb_serial_word_deserializer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_deserializer_if.sv
// Handshake and serial-input bundle for serial_word_deserializer.
// master: the bit source and word consumer; slave: the deserializer.
interface serial_word_deserializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             din;
  logic             bit_en;
  logic             word_ready;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output start, din, bit_en, word_ready,
    input  word, word_valid, busy, overrun
  );

  modport slave (
    input  start, din, bit_en, word_ready,
    output word, word_valid, busy, overrun
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// Framed serial-to-parallel word collector with a single-entry valid/ready output
// register; a word completed while the output is still occupied is dropped.
module serial_word_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  serial_word_deserializer_if.slave bus
);
  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sr_q, sr_next;
  logic [WIDTH-1:0] word_q;
  logic             valid_q, ovr_q;
  logic             accept, complete, load;

  always_comb begin
    state_d  = state_q;
    sr_next  = sr_q;
    accept   = (state_q == SHIFT) && bus.bit_en && !bus.start;
    complete = accept && (cnt_q == LAST);
    load     = complete && (!valid_q || bus.word_ready);
    if (MSB_FIRST) sr_next = {sr_q[WIDTH-2:0], bus.din};
    else           sr_next = {bus.din, sr_q[WIDTH-1:1]};
    if (bus.start)     state_d = SHIFT;
    else if (complete) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // start takes priority over a coincident strobe and clears the partial frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (bus.start) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (accept) begin
      sr_q  <= sr_next;
      cnt_q <= complete ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= complete && !load;
      if (load) begin
        word_q  <= sr_next;
        valid_q <= 1'b1;
      end else if (valid_q && bus.word_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.word       = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream
// and are checked against a frame-level reference model.
module tb_serial_word_deserializer;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_word_deserializer_if #(.WIDTH(W)) if_m ();
  serial_word_deserializer_if #(.WIDTH(W)) if_l ();

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .bus(if_m)
  );
  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .bus(if_l)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         edge_no;
    bit         busy;
    bit         ovr;
    bit         valid;
    logic [W-1:0] wm;
    logic [W-1:0] wl;
  } exp_t;

  exp_t         eq[$];
  logic [W-1:0] wq_m[$];
  logic [W-1:0] wq_l[$];

  // reference model state: frame open?, output slot occupied?, bits so far
  bit           inframe = 1'b0;
  bit           occ     = 1'b0;
  bit           bits[$];
  logic [W-1:0] cw_m = '0;
  logic [W-1:0] cw_l = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit d, input bit b, input bit rdy);
    exp_t         e;
    bit           ovr    = 1'b0;
    bit           loaded = 1'b0;
    bit           xfer;
    logic [W-1:0] vm, vl;
    if (!r) begin
      inframe = 1'b0;
      occ     = 1'b0;
      bits.delete();
      cw_m = '0;
      cw_l = '0;
      wq_m.delete();
      wq_l.delete();
    end else begin
      xfer = occ && rdy;
      if (s) begin
        inframe = 1'b1;
        bits.delete();
      end else if (inframe && b) begin
        bits.push_back(d);
        if (bits.size() == W) begin
          vm = '0;
          vl = '0;
          for (int unsigned i = 0; i < W; i++) begin
            vm[W-1-i] = bits[i];
            vl[i]     = bits[i];
          end
          inframe = 1'b0;
          bits.delete();
          if (!occ || rdy) begin
            cw_m = vm;
            cw_l = vl;
            wq_m.push_back(vm);
            wq_l.push_back(vl);
            occ    = 1'b1;
            loaded = 1'b1;
          end else begin
            ovr = 1'b1;
          end
        end
      end
      if (xfer && !loaded) occ = 1'b0;
    end
    e.edge_no = cyc + 1;
    e.busy    = inframe;
    e.ovr     = ovr;
    e.valid   = occ;
    e.wm      = cw_m;
    e.wl      = cw_l;
    eq.push_back(e);
  endtask

  task automatic step(input bit r, input bit s, input bit d, input bit b, input bit rdy);
    reset           = r;
    if_m.start      = s;   if_l.start      = s;
    if_m.din        = d;   if_l.din        = d;
    if_m.bit_en     = b;   if_l.bit_en     = b;
    if_m.word_ready = rdy; if_l.word_ready = rdy;
    model_edge(r, s, d, b, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] v, input int gap, input bit rdy_last);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, 1'b0, v[i], 1'b1, (i == 0) ? rdy_last : 1'b0);
      if (i != 0) repeat (gap) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic async_reset_check();
    reset = 1'b0;
    #1;
    chk("rst_word_m",    32'(if_m.word),  0);
    chk("rst_valid_m",   32'(if_m.word_valid), 0);
    chk("rst_busy_m",    32'(if_m.busy),  0);
    chk("rst_overrun_m", 32'(if_m.overrun), 0);
    chk("rst_word_l",    32'(if_l.word),  0);
    chk("rst_valid_l",   32'(if_l.word_valid), 0);
    chk("rst_busy_l",    32'(if_l.busy),  0);
    chk("rst_overrun_l", 32'(if_l.overrun), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor: per-edge flags/word state, plus word popped on every transfer
  always @(negedge clk) begin
    exp_t e;
    while (eq.size() > 0 && eq[0].edge_no < cyc) void'(eq.pop_front());
    if (eq.size() > 0 && eq[0].edge_no == cyc) begin
      e = eq.pop_front();
      if (!reset) begin
        e.busy = 1'b0; e.ovr = 1'b0; e.valid = 1'b0; e.wm = '0; e.wl = '0;
      end
      chk("busy_m",    32'(if_m.busy),       32'(e.busy));
      chk("overrun_m", 32'(if_m.overrun),    32'(e.ovr));
      chk("valid_m",   32'(if_m.word_valid), 32'(e.valid));
      chk("word_m",    32'(if_m.word),       32'(e.wm));
      chk("busy_l",    32'(if_l.busy),       32'(e.busy));
      chk("overrun_l", 32'(if_l.overrun),    32'(e.ovr));
      chk("valid_l",   32'(if_l.word_valid), 32'(e.valid));
      chk("word_l",    32'(if_l.word),       32'(e.wl));
    end
    if (reset && if_m.word_valid && if_m.word_ready) begin
      if (wq_m.size() == 0) chk("xfer_m_unexpected", 1, 0);
      else                  chk("xfer_word_m", 32'(if_m.word), 32'(wq_m.pop_front()));
    end
    if (reset && if_l.word_valid && if_l.word_ready) begin
      if (wq_l.size() == 0) chk("xfer_l_unexpected", 1, 0);
      else                  chk("xfer_word_l", 32'(if_l.word), 32'(wq_l.pop_front()));
    end
  end

  initial begin
    reset = 1'b0;
    if_m.start = 1'b0; if_m.din = 1'b0; if_m.bit_en = 1'b0; if_m.word_ready = 1'b0;
    if_l.start = 1'b0; if_l.din = 1'b0; if_l.bit_en = 1'b0; if_l.word_ready = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // MSB-first frame, continuous strobes, no ready
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy_after_start", 32'(if_m.busy), 1);
    send_word(8'hA5, 0, 1'b0);
    chk("msb_word_A5",  32'(if_m.word), 32'h A5);
    chk("msb_valid",    32'(if_m.word_valid), 1);
    chk("msb_busy_low", 32'(if_m.busy), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("msb_valid_cleared", 32'(if_m.word_valid), 0);
    chk("msb_word_held",     32'(if_m.word), 32'h A5);

    // LSB-first with two idle cycles between strobes
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'hA5, 2, 1'b0);
    chk("lsb_word_A5", 32'(if_l.word), 32'h A5);
    chk("lsb_valid",   32'(if_l.word_valid), 1);
    chk("lsb_no_ovr",  32'(if_l.overrun), 0);

    // second frame dropped while A5 pending
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 0, 1'b0);
    chk("ovr_pulse",     32'(if_m.overrun), 1);
    chk("ovr_word_kept", 32'(if_m.word), 32'h A5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_one_cycle", 32'(if_m.overrun), 0);

    // completion coincident with transfer
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 0, 1'b1);
    chk("b2b_word_3C", 32'(if_m.word), 32'h 3C);
    chk("b2b_valid",   32'(if_m.word_valid), 1);
    chk("b2b_no_ovr",  32'(if_m.overrun), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // restart after 5 bits with a coincident strobe
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_word(8'h81, 0, 1'b0);
    chk("restart_word_81", 32'(if_m.word), 32'h 81);
    chk("restart_valid",   32'(if_m.word_valid), 1);

    // reset mid-frame with a word pending, then strobes without start
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    async_reset_check();
    repeat (4) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("postrst_busy",  32'(if_m.busy), 0);
      chk("postrst_valid", 32'(if_m.word_valid), 0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(199, 0) != 0,
           $urandom_range(19, 0) == 0,
           1'($urandom),
           $urandom_range(9, 0) < 6,
           $urandom_range(9, 0) < 3);
    end

    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("drain_m", 32'(wq_m.size()), 0);
    chk("drain_l", 32'(wq_l.size()), 0);
    chk("eq_drained", 32'(eq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
